// File: rtl/noc_pkg.sv
// Purpose: shared flit layout for the virtual-router network interface.
// Fields (MSB first): dest | src | payload.
package noc_pkg;

    localparam int unsigned FLIT_W    = 32;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DEST_MSB  = 31;
    localparam int unsigned DEST_LSB  = 28;
    localparam int unsigned SRC_MSB   = 27;
    localparam int unsigned SRC_LSB   = 24;
    localparam int unsigned PAYLOAD_W = FLIT_W - 2 * ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0]    dest;
        logic [ADDR_W-1:0]    src;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

endpackage

// File: rtl/noc_bus.sv
// Purpose: valid/ready flit channel between a router and an endpoint.
// Signals: data (W bits), valid (source->sink), ready (sink->source).
interface bus #(
    parameter int unsigned W = 32
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport source (output data, output valid, input ready);
    modport sink   (input data, input valid, output ready);
endinterface

// File: rtl/ni_fifo.sv
// Purpose: synchronous FIFO, pointer-based with an extra wrap bit.
// Ports: clk, reset (sync, active-high), push/din, pop/dout (head), full, empty.
// A push while full and a pop while empty are ignored.
module ni_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the write side lapped the read side.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Pointer advance; power-of-two depth makes the index wrap for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q + CNT_W'(do_push);
        rd_ptr_d = rd_ptr_q + CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
            end
        end
    end

endmodule

// File: rtl/vr_endpoint.sv
// Purpose: network endpoint attached to a virtual router.
//   TX: user flits are stamped with VR_ID as src and queued toward net_src.
//   RX: flits from net_sink addressed to VR_ID are queued to the user as
//       {src, payload}; misaddressed flits are consumed and counted.
// Ports: clk_rtr, reset (sync, active-high), net_src (bus.source),
//   net_sink (bus.sink), tx_valid/tx_ready/tx_dest/tx_payload,
//   rx_valid/rx_ready/rx_src/rx_payload, drop_count (saturating).
module vr_endpoint
    import noc_pkg::*;
#(
    parameter int unsigned RANK             = 2,
    parameter int unsigned DATA_PACKET_SIZE = 32,
    parameter int unsigned VR_ID            = 9,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                                 clk_rtr,
    input  logic                                 reset,
    bus.source                                   net_src,
    bus.sink                                     net_sink,
    input  logic                                 tx_valid,
    output logic                                 tx_ready,
    input  logic [ADDR_W-1:0]                    tx_dest,
    input  logic [DATA_PACKET_SIZE-2*ADDR_W-1:0] tx_payload,
    output logic                                 rx_valid,
    input  logic                                 rx_ready,
    output logic [ADDR_W-1:0]                    rx_src,
    output logic [DATA_PACKET_SIZE-2*ADDR_W-1:0] rx_payload,
    output logic [15:0]                          drop_count
);

    localparam int unsigned PW    = DATA_PACKET_SIZE - 2 * ADDR_W;
    localparam int unsigned RX_W  = ADDR_W + PW;
    localparam logic [ADDR_W-1:0] MY_ID = ADDR_W'(VR_ID);

    // Elaboration-time parameter sanity check.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || VR_ID > 15) begin : g_bad_param
        $error("vr_endpoint (rank %0d): FIFO_DEPTH must be a power of two >= 2 and VR_ID < 16", RANK);
    end

    logic                        tx_full, tx_empty;
    logic [DATA_PACKET_SIZE-1:0] tx_flit;
    logic [DATA_PACKET_SIZE-1:0] tx_head;

    logic                        rx_full, rx_empty;
    logic                        sink_xfer;
    logic                        dest_match;
    logic [RX_W-1:0]             rx_head;

    logic [15:0]                 drop_count_q, drop_count_d;

    // Transmit path.
    assign tx_flit       = {tx_dest, MY_ID, tx_payload};
    assign tx_ready      = !tx_full;
    assign net_src.valid = !tx_empty;
    assign net_src.data  = tx_head;

    ni_fifo #(
        .WIDTH (DATA_PACKET_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk_rtr),
        .reset (reset),
        .push  (tx_valid),
        .din   (tx_flit),
        .pop   (net_src.ready),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Receive path; ready comes only from FIFO pointer flops.
    assign net_sink.ready = !rx_full;
    assign sink_xfer      = net_sink.valid && !rx_full;
    assign dest_match     = (net_sink.data[DATA_PACKET_SIZE-1 -: ADDR_W] == MY_ID);
    assign rx_valid       = !rx_empty;
    assign rx_src         = rx_head[RX_W-1 -: ADDR_W];
    assign rx_payload     = rx_head[PW-1:0];

    ni_fifo #(
        .WIDTH (RX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk_rtr),
        .reset (reset),
        .push  (sink_xfer && dest_match),
        .din   (net_sink.data[RX_W-1:0]),
        .pop   (rx_ready),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Saturating count of misaddressed flits.
    always_comb begin
        drop_count_d = drop_count_q;
        if (sink_xfer && !dest_match && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_rtr) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_vr_endpoint.sv
// Self-checking bench for vr_endpoint: directed tables/sequences plus a
// randomized run against a queue-based reference model.
module tb_vr_endpoint;

    logic        clk_rtr;
    logic        reset;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_dest;
    logic [23:0] tx_payload;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  rx_src;
    logic [23:0] rx_payload;
    logic [15:0] drop_count;

    bus #(.W(32)) net_src_if ();
    bus #(.W(32)) net_sink_if ();

    int n_tests = 0;
    int n_fail  = 0;

    vr_endpoint #(
        .RANK             (2),
        .DATA_PACKET_SIZE (32),
        .VR_ID            (9),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk_rtr    (clk_rtr),
        .reset      (reset),
        .net_src    (net_src_if),
        .net_sink   (net_sink_if),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_dest    (tx_dest),
        .tx_payload (tx_payload),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_src     (rx_src),
        .rx_payload (rx_payload),
        .drop_count (drop_count)
    );

    initial clk_rtr = 1'b0;
    always #5 clk_rtr = ~clk_rtr;

    typedef struct {
        logic [31:0] flit;
        logic        exp_valid;
        logic [3:0]  exp_src;
        logic [23:0] exp_pl;
        logic [15:0] exp_drop;
    } rx_vec_t;

    rx_vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_rtr);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tx_ready"},   32'(tx_ready), 32'd1);
        chk({tag, "_src_valid"},  32'(net_src_if.valid), 32'd0);
        chk({tag, "_sink_ready"}, 32'(net_sink_if.ready), 32'd1);
        chk({tag, "_rx_valid"},   32'(rx_valid), 32'd0);
        chk({tag, "_drop"},       32'(drop_count), 32'd0);
    endtask

    initial begin
        logic        acc;
        logic [31:0] txq [$];
        logic [27:0] rxq [$];
        logic [31:0] exp_w;
        logic [3:0]  d;
        int          tx_sent, sink_sent, drop_exp, cyc;
        logic        tx_x, ns_x, sk_x, rx_x;

        vecs[0] = '{32'h92123456, 1'b1, 4'h2, 24'h123456, 16'd0};
        vecs[1] = '{32'h50AAAAAA, 1'b0, 4'h0, 24'h000000, 16'd1};
        vecs[2] = '{32'h5B000001, 1'b0, 4'h0, 24'h000000, 16'd2};
        vecs[3] = '{32'h57FFFFFF, 1'b0, 4'h0, 24'h000000, 16'd3};
        vecs[4] = '{32'h9F000001, 1'b1, 4'hF, 24'h000001, 16'd3};
        vecs[5] = '{32'h99C0FFEE, 1'b1, 4'h9, 24'hC0FFEE, 16'd3};
        vecs[6] = '{32'h89000000, 1'b0, 4'h0, 24'h000000, 16'd4};

        reset = 1'b1;
        tx_valid = 1'b0; tx_dest = '0; tx_payload = '0;
        rx_ready = 1'b0;
        net_src_if.ready  = 1'b0;
        net_sink_if.valid = 1'b0;
        net_sink_if.data  = '0;
        tick(); tick();
        reset = 1'b0;
        check_idle("reset");

        // Single TX flit with consumer ready: one cycle latency, valid for one cycle.
        net_src_if.ready = 1'b1;
        tx_valid = 1'b1; tx_dest = 4'h3; tx_payload = 24'hABCDEF;
        chk("single_tx_ready0", 32'(tx_ready), 32'd1);
        tick();
        tx_valid = 1'b0;
        chk("single_tx_valid", 32'(net_src_if.valid), 32'd1);
        chk("single_tx_data",  net_src_if.data, 32'h39ABCDEF);
        tick();
        chk("single_tx_gone",  32'(net_src_if.valid), 32'd0);

        // Fill TX with consumer stalled, then drain in order.
        net_src_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1; tx_dest = 4'h1; tx_payload = 24'(i + 1);
            chk("fill_tx_ready", 32'(tx_ready), 32'd1);
            tick();
        end
        tx_valid = 1'b1; tx_payload = 24'h5;
        chk("full_tx_ready", 32'(tx_ready), 32'd0);
        tick();
        chk("full_tx_stall", 32'(tx_ready), 32'd0);
        net_src_if.ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("burst_valid", 32'(net_src_if.valid), 32'd1);
            chk("burst_data",  net_src_if.data, {4'h1, 4'h9, 24'(k + 1)});
            acc = tx_valid && tx_ready;
            tick();
            if (acc) tx_valid = 1'b0;
        end
        chk("fifth_accepted", 32'(tx_valid), 32'd0);
        chk("burst_empty",    32'(net_src_if.valid), 32'd0);

        // RX table: one flit per entry, popped right after checking.
        foreach (vecs[v]) begin
            chk("tbl_sink_ready", 32'(net_sink_if.ready), 32'd1);
            net_sink_if.valid = 1'b1;
            net_sink_if.data  = vecs[v].flit;
            tick();
            net_sink_if.valid = 1'b0;
            chk("tbl_rx_valid", 32'(rx_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                chk("tbl_rx_src", 32'(rx_src), 32'(vecs[v].exp_src));
                chk("tbl_rx_pl",  32'(rx_payload), 32'(vecs[v].exp_pl));
            end
            chk("tbl_drop", 32'(drop_count), 32'(vecs[v].exp_drop));
            chk("tbl_sink_ready_after", 32'(net_sink_if.ready), 32'd1);
            if (rx_valid) begin
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
                chk("tbl_rx_popped", 32'(rx_valid), 32'd0);
            end
        end

        // Fill RX with user stalled and leave a TX flit queued, then reset.
        net_src_if.ready = 1'b0;
        tx_valid = 1'b1; tx_dest = 4'h7; tx_payload = 24'h777777;
        for (int i = 0; i < 4; i++) begin
            chk("rxfill_ready", 32'(net_sink_if.ready), 32'd1);
            net_sink_if.valid = 1'b1;
            net_sink_if.data  = {4'h9, 4'(i), 24'(i * 3)};
            tick();
            tx_valid = 1'b0;
        end
        net_sink_if.valid = 1'b0;
        chk("rxfull_ready", 32'(net_sink_if.ready), 32'd0);
        chk("rxfull_valid", 32'(rx_valid), 32'd1);
        chk("txq_valid",    32'(net_src_if.valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("midreset");
        net_src_if.ready = 1'b1;
        rx_ready = 1'b1;
        tick();
        check_idle("postreset");

        // Randomized traffic on both directions against a queue model.
        tx_sent = 0; sink_sent = 0; drop_exp = 0; cyc = 0;
        tx_valid = 1'b0; net_sink_if.valid = 1'b0;
        while ((tx_sent < 1000 || sink_sent < 1000 || txq.size() != 0 || rxq.size() != 0 ||
                tx_valid || net_sink_if.valid) && cyc < 20000) begin
            if (!tx_valid && tx_sent < 1000 && $urandom_range(3) != 0) begin
                tx_valid = 1'b1; tx_dest = 4'($urandom); tx_payload = 24'($urandom);
                tx_sent++;
            end
            if (!net_sink_if.valid && sink_sent < 1000 && $urandom_range(3) != 0) begin
                d = ($urandom_range(1) == 1) ? 4'h9 : 4'($urandom);
                net_sink_if.data  = {d, 4'($urandom), 24'($urandom)};
                net_sink_if.valid = 1'b1;
                sink_sent++;
            end
            net_src_if.ready = ($urandom_range(3) != 0);
            rx_ready         = ($urandom_range(3) != 0);

            chk("rnd_tx_ready",   32'(tx_ready), 32'(txq.size() < 4));
            chk("rnd_src_valid",  32'(net_src_if.valid), 32'(txq.size() != 0));
            chk("rnd_sink_ready", 32'(net_sink_if.ready), 32'(rxq.size() < 4));
            chk("rnd_rx_valid",   32'(rx_valid), 32'(rxq.size() != 0));

            tx_x = tx_valid && tx_ready;
            ns_x = net_src_if.valid && net_src_if.ready;
            sk_x = net_sink_if.valid && net_sink_if.ready;
            rx_x = rx_valid && rx_ready;

            if (ns_x) begin
                exp_w = (txq.size() != 0) ? txq.pop_front() : 32'hxxxxxxxx;
                chk("rnd_src_data", net_src_if.data, exp_w);
            end
            if (rx_x) begin
                exp_w = (rxq.size() != 0) ? 32'(rxq.pop_front()) : 32'hxxxxxxxx;
                chk("rnd_rx_data", {4'h0, rx_src, rx_payload}, exp_w);
            end
            if (tx_x) txq.push_back({tx_dest, 4'h9, tx_payload});
            if (sk_x) begin
                if (net_sink_if.data[31:28] == 4'h9) rxq.push_back(net_sink_if.data[27:0]);
                else if (drop_exp < 65535) drop_exp++;
            end

            tick();
            cyc++;
            if (tx_x) tx_valid = 1'b0;
            if (sk_x) net_sink_if.valid = 1'b0;
        end
        chk("rnd_completed", 32'(cyc < 20000), 32'd1);
        chk("rnd_drop_count", 32'(drop_count), 32'(drop_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
